hazard_stall_ctrl: RTL and testbench

Pipeline hazard sequencer for the 5-stage MIPS core. It sits beside the ID stage and drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush. It detects load-use hazards and issues the multiply/divide unit (MDU). It tracks MDU occupancy with a down-counter and stalls HI/LO readers and back-to-back MDU ops. It also flushes wrong-path instructions on a taken branch resolved in EX. Register-file read-after-write in WB is handled by the WB forwarding path, not here.

---
 rtl/hazard_stall_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard sequencer: load-use stall, MDU occupancy, branch flush
module hazard_stall_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_is_mdu,
  input  logic        id_reads_hilo,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_WriteRegister,
  input  logic        branch_taken_ex,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEX_bubble,
  output logic        IFID_flush,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic [15:0] stall_count
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MDU_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] mdu_cnt;
  logic [CNT_W-1:0] mdu_cnt_nxt;

  logic load_hz;
  logic mdu_hz;
  logic stall;

  // Hazard detection; $0 is hardwired zero so a load targeting it never creates a dependency
  always_comb begin
    mdu_busy = (state == ST_MDU_BUSY) & ~reset;
    load_hz  = ex_MemRead & (ex_WriteRegister != 5'd0) &
               ((ex_WriteRegister == id_rs) | (id_uses_rt & (ex_WriteRegister == id_rt)));
    mdu_hz   = mdu_busy & (id_reads_hilo | id_is_mdu);
    stall    = (load_hz | mdu_hz) & ~branch_taken_ex;
  end

  // Pipeline control: a taken branch flush wins over any stall, stall wins over normal flow
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEX_bubble = 1'b0;
    IFID_flush  = 1'b0;
    if (!reset) begin
      if (branch_taken_ex) begin
        IFID_flush  = 1'b1;
        IDEX_bubble = 1'b1;
      end else if (stall) begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEX_bubble = 1'b1;
      end
    end
    // An MDU op already busy is covered by mdu_hz, so start can never overlap occupancy
    mdu_start = id_is_mdu & ~stall & ~branch_taken_ex & ~reset;
  end

  // MDU occupancy sequencing: counter loaded at launch, busy ends the cycle after it reads 1
  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    case (state)
      ST_RUN: begin
        if (mdu_start) begin
          state_nxt   = ST_MDU_BUSY;
          mdu_cnt_nxt = CNT_LOAD;
        end
      end
      ST_MDU_BUSY: begin
        if (mdu_cnt <= CNT_ONE) begin
          state_nxt   = ST_RUN;
          mdu_cnt_nxt = '0;
        end else begin
          mdu_cnt_nxt = mdu_cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt   = ST_RUN;
        mdu_cnt_nxt = '0;
      end
    endcase
  end

  // State and counter registers; reset abandons any in-flight MDU tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      mdu_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if (!PCWrite && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_is_mdu;
  logic        id_reads_hilo;
  logic        ex_MemRead;
  logic [4:0]  ex_WriteRegister;
  logic        branch_taken_ex;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEX_bubble;
  logic        IFID_flush;
  logic        mdu_start;
  logic        mdu_busy;
  logic [15:0] stall_count;

  hazard_stall_ctrl #(.MDU_LATENCY(4), .CNT_W(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .id_is_mdu        (id_is_mdu),
    .id_reads_hilo    (id_reads_hilo),
    .ex_MemRead       (ex_MemRead),
    .ex_WriteRegister (ex_WriteRegister),
    .branch_taken_ex  (branch_taken_ex),
    .PCWrite          (PCWrite),
    .IFIDWrite        (IFIDWrite),
    .IDEX_bubble      (IDEX_bubble),
    .IFID_flush       (IFID_flush),
    .mdu_start        (mdu_start),
    .mdu_busy         (mdu_busy),
    .stall_count      (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pc;
    logic        ifid;
    logic        bub;
    logic        fl;
    logic        st;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input string field, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
  endtask

  // Monitor: outputs are combinational, so each cycle with a pending expectation is compared
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "PCWrite",     {15'd0, PCWrite},     {15'd0, e.pc});
      chk(e.name, "IFIDWrite",   {15'd0, IFIDWrite},   {15'd0, e.ifid});
      chk(e.name, "IDEX_bubble", {15'd0, IDEX_bubble}, {15'd0, e.bub});
      chk(e.name, "IFID_flush",  {15'd0, IFID_flush},  {15'd0, e.fl});
      chk(e.name, "mdu_start",   {15'd0, mdu_start},   {15'd0, e.st});
      chk(e.name, "mdu_busy",    {15'd0, mdu_busy},    {15'd0, e.busy});
      chk(e.name, "stall_count", stall_count,          e.cnt);
    end
  end

  // Apply one cycle of inputs; when push=1 queue the expected outputs for that cycle
  task automatic step(input string name, input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mdu, input logic hilo, input logic mr,
                      input logic [4:0] wr, input logic br,
                      input logic e_pc, input logic e_ifid, input logic e_bub, input logic e_fl,
                      input logic e_st, input logic e_busy, input logic [15:0] e_cnt, input logic push);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_is_mdu = mdu;
    id_reads_hilo = hilo; ex_MemRead = mr; ex_WriteRegister = wr; branch_taken_ex = br;
    if (push) begin
      e.name = name; e.pc = e_pc; e.ifid = e_ifid; e.bub = e_bub; e.fl = e_fl;
      e.st = e_st; e.busy = e_busy; e.cnt = e_cnt;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_is_mdu = 1'b0;
    id_reads_hilo = 1'b0; ex_MemRead = 1'b0; ex_WriteRegister = '0; branch_taken_ex = 1'b0;

    //         name          rst rs    rt    urt mdu hl  mr  wr    br   pc ifid bub fl st busy cnt       push
    step("reset0",        1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd0, 1);
    step("reset_load",    1, 5'd8, 5'd0, 0, 1, 0, 1, 5'd8, 0,   1, 1, 0, 0, 0, 0, 16'd0, 1);
    step("lu_rs",         0, 5'd8, 5'd0, 0, 0, 0, 1, 5'd8, 0,   0, 0, 1, 0, 0, 0, 16'd0, 1);
    step("idle1",         0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd1, 1);
    step("lu_rt_unused",  0, 5'd3, 5'd8, 0, 0, 0, 1, 5'd8, 0,   1, 1, 0, 0, 0, 0, 16'd1, 1);
    step("lu_rt_used",    0, 5'd3, 5'd8, 1, 0, 0, 1, 5'd8, 0,   0, 0, 1, 0, 0, 0, 16'd1, 1);
    step("r0_filter",     0, 5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd2, 1);
    step("idle2",         0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd2, 1);
    step("mult_c0",       0, 5'd4, 5'd5, 1, 1, 0, 0, 5'd0, 0,   1, 1, 0, 0, 1, 0, 16'd2, 1);
    step("mfhi_c1",       0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0,   0, 0, 1, 0, 0, 1, 16'd2, 1);
    step("mfhi_c2",       0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0,   0, 0, 1, 0, 0, 1, 16'd3, 1);
    step("mfhi_c3",       0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0,   0, 0, 1, 0, 0, 1, 16'd4, 1);
    step("mfhi_c4",       0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0,   0, 0, 1, 0, 0, 1, 16'd5, 1);
    step("mfhi_c5_issue", 0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd6, 1);
    step("mdu_a",         0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0,   1, 1, 0, 0, 1, 0, 16'd6, 1);
    step("mdu_b2b",       0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0,   0, 0, 1, 0, 0, 1, 16'd6, 1);
    step("mdu_b2b_br",    0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 1,   1, 1, 1, 1, 0, 1, 16'd7, 1);
    step("mdu_tail1",     0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 1, 16'd7, 1);
    step("mdu_tail2",     0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 1, 16'd7, 1);
    step("mdu_done",      0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd7, 1);
    step("br_over_lu",    0, 5'd9, 5'd0, 0, 0, 0, 1, 5'd9, 1,   1, 1, 1, 1, 0, 0, 16'd7, 1);
    step("idle3",         0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd7, 1);
    step("br_over_mdu",   0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 1,   1, 1, 1, 1, 0, 0, 16'd7, 1);
    step("still_run",     0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd7, 1);
    step("rst_mdu_start", 0, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0,   1, 1, 0, 0, 1, 0, 16'd7, 1);
    step("rst_mdu_busy1", 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 1, 16'd7, 1);
    step("rst_mdu_assert",1, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd7, 1);
    step("rst_mdu_after", 0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'd0, 1);

    for (int i = 0; i < 70000; i++)
      step("sat_fill",    0, 5'd7, 5'd0, 0, 0, 0, 1, 5'd7, 0,   0, 0, 1, 0, 0, 0, 16'd0, 0);
    step("sat_stall",     0, 5'd7, 5'd0, 0, 0, 0, 1, 5'd7, 0,   0, 0, 1, 0, 0, 0, 16'hFFFF, 1);
    step("sat_hold",      0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 0, 16'hFFFF, 1);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
